// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmitter slice.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Counter width able to hold n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts clock cycles and pulses tick on the last cycle of each bit.
module bit_timer
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned   CW   = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/serial_tx.sv
// Bit-serial frame transmitter: start, WIDTH data bits LSB first, optional even parity, stop.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned   BW       = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_nxt;
  logic [BW-1:0]    bit_cnt_q;
  logic             parity_q;
  logic             tx_q;
  logic             done_q;
  logic             tick;

  // Timer is held cleared in IDLE so every frame's first bit starts at count 0.
  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear_i(state_q == IDLE),
    .tick_o (tick)
  );

  assign shift_nxt = shift_q >> 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= IDLE_LEVEL;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tx_q <= IDLE_LEVEL;
          if (tx_valid) begin
            shift_q   <= tx_data;
            parity_q  <= ^tx_data;
            bit_cnt_q <= '0;
            tx_q      <= START_LEVEL;
            state_q   <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shift_q <= shift_nxt;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              if (PARITY_EN != 0) begin
                tx_q    <= parity_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= IDLE_LEVEL;
                state_q <= STOP;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              tx_q      <= shift_nxt[0];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx_q    <= IDLE_LEVEL;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            done_q  <= 1'b1;
            tx_q    <= IDLE_LEVEL;
            state_q <= IDLE;
          end
        end
        default: begin
          tx_q    <= IDLE_LEVEL;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (state_q == IDLE);
  assign busy     = ~tx_ready;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed and randomized checks of serial_tx against a frame-level bit-list model.
module tb_serial_tx;

  localparam int unsigned WA = 8, CA = 4, PA = 1;
  localparam int unsigned WB = 8, CB = 1, PB = 0;
  localparam int unsigned FA = (2 + WA + PA) * CA;
  localparam int unsigned FB = (2 + WB + PB) * CB;

  logic clk = 1'b0;
  logic reset;

  logic [WA-1:0] a_data;
  logic          a_valid, a_ready, a_tx, a_busy, a_done;
  logic [WB-1:0] b_data;
  logic          b_valid, b_ready, b_tx, b_busy, b_done;

  int checks = 0;
  int errors = 0;
  int a_dones = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (a_done === 1'b1) a_dones++;

  serial_tx #(.WIDTH(WA), .CLKS_PER_BIT(CA), .PARITY_EN(PA)) dut_a (
    .clk(clk), .reset(reset), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .tx(a_tx), .busy(a_busy), .done(a_done)
  );

  serial_tx #(.WIDTH(WB), .CLKS_PER_BIT(CB), .PARITY_EN(PB)) dut_b (
    .clk(clk), .reset(reset), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .tx(b_tx), .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame as a list of line levels, one entry per bit period.
  function automatic void build(input logic [15:0] d, input int unsigned w,
                                input int unsigned par, output bit q[$]);
    int unsigned ones = 0;
    q = {};
    q.push_back(1'b0);
    for (int unsigned i = 0; i < w; i++) begin
      q.push_back(d[i]);
      ones += d[i];
    end
    if (par != 0) q.push_back(bit'(ones % 2));
    q.push_back(1'b1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame on dut_a; with hold_valid the next word nd is presented for a back-to-back accept.
  task automatic frame_a(input logic [7:0] d, input bit hold_valid, input logic [7:0] nd);
    bit q[$];
    build({8'h00, d}, WA, PA, q);
    a_valid = 1'b1;
    a_data  = d;
    step();
    a_valid = hold_valid;
    for (int unsigned i = 0; i < FA; i++) begin
      chk("a_tx", a_tx, q[i / CA]);
      chk("a_ready", a_ready, 0);
      chk("a_busy", a_busy, 1);
      chk("a_done", a_done, 0);
      a_data = (hold_valid && i == FA - 1) ? nd : 8'($urandom);
      step();
    end
    chk("a_done_pulse", a_done, 1);
    chk("a_ready_end", a_ready, 1);
    chk("a_tx_end", a_tx, 1);
  endtask

  task automatic frame_b(input logic [7:0] d);
    bit q[$];
    build({8'h00, d}, WB, PB, q);
    b_valid = 1'b1;
    b_data  = d;
    step();
    b_valid = 1'b0;
    for (int unsigned i = 0; i < FB; i++) begin
      chk("b_tx", b_tx, q[i / CB]);
      chk("b_ready", b_ready, 0);
      chk("b_done", b_done, 0);
      b_data = 8'($urandom);
      step();
    end
    chk("b_done_pulse", b_done, 1);
    chk("b_ready_end", b_ready, 1);
    chk("b_tx_end", b_tx, 1);
  endtask

  initial begin
    bit q[$];
    int base;

    // Reset held with valid high: no frame may start.
    reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hA5; b_data = 8'h80;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_a_tx", a_tx, 1);
      chk("rst_a_ready", a_ready, 1);
      chk("rst_a_busy", a_busy, 0);
      chk("rst_a_done", a_done, 0);
      chk("rst_b_tx", b_tx, 1);
      chk("rst_b_ready", b_ready, 1);
    end
    a_valid = 1'b0; b_valid = 1'b0; reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_a_tx", a_tx, 1);
      chk("idle_a_ready", a_ready, 1);
    end

    frame_a(8'hA5, 1'b0, 8'h00);
    step();
    chk("a5_done_drop", a_done, 0);

    frame_a(8'h07, 1'b0, 8'h00);
    step();
    chk("07_done_drop", a_done, 0);

    // Back-to-back: second accept at k+F+1, so its start bit shows at k+45.
    base = a_dones;
    frame_a(8'h3C, 1'b1, 8'hC3);
    frame_a(8'hC3, 1'b0, 8'h00);
    step();
    chk("b2b_done_drop", a_done, 0);
    chk("b2b_done_count", 32'(a_dones - base), 2);

    // Reset during data bit 3 of 0xFF.
    base = a_dones;
    build(16'h00FF, WA, PA, q);
    a_valid = 1'b1; a_data = 8'hFF;
    step();
    a_valid = 1'b0;
    for (int unsigned i = 0; i < 4 * CA + 1; i++) begin
      chk("rstmid_tx", a_tx, q[i / CA]);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid_tx_hi", a_tx, 1);
    chk("rstmid_ready", a_ready, 1);
    chk("rstmid_done", a_done, 0);
    for (int unsigned i = 0; i < FA; i++) begin
      step();
      chk("rstmid_idle_tx", a_tx, 1);
      chk("rstmid_idle_done", a_done, 0);
    end
    chk("rstmid_no_done", 32'(a_dones - base), 0);
    frame_a(8'h01, 1'b0, 8'h00);
    step();

    // Minimum timing configuration.
    frame_b(8'h80);
    step();
    chk("b_done_drop", b_done, 0);

    // Randomized words with random idle gaps.
    for (int n = 0; n < 5; n++) begin
      int unsigned gap = $urandom_range(0, 3);
      for (int unsigned g = 0; g < gap; g++) begin
        step();
        chk("gap_a_tx", a_tx, 1);
        chk("gap_a_ready", a_ready, 1);
      end
      frame_a(8'($urandom), 1'b0, 8'h00);
      frame_b(8'($urandom));
    end
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
